// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch front end: key sync/debounce/press, tick divider, IDLE/RUN/PAUSED FSM
// Optional lap key and lap output enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
  parameter int CLK_HZ    = 50000000,
  parameter int TICK_HZ   = 100,
  parameter int DB_CYCLES = 1000000
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       key_start_n,
  input  logic       key_clr_n,
`ifdef STOPWATCH_LAP_EN
  input  logic       key_lap_n,
  output logic       lap,
`endif
  output logic       en,
  output logic       pause,
  output logic       clr,
  output logic [1:0] state
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
`ifdef STOPWATCH_LAP_EN
  localparam int NK = 3;
`else
  localparam int NK = 2;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_PAUSED = 2'b10
  } state_t;

  // Key index 0 = start, 1 = clear, 2 = lap (when present)
  logic [NK-1:0]   w_raw;
  logic [NK-1:0]   r_sync1;
  logic [NK-1:0]   r_sync2;
  logic [NK-1:0]   r_db;
  logic [NK-1:0]   r_db_prev;
  logic [DB_W-1:0] r_db_cnt [NK];
  logic [NK-1:0]   w_press;

  logic [DIV_W-1:0] r_div_cnt;
  logic             w_en;

  state_t r_state;
  logic   r_pause;
  logic   r_clr;

`ifdef STOPWATCH_LAP_EN
  logic r_lap;
  assign w_raw = {key_lap_n, key_clr_n, key_start_n};
  assign lap   = r_lap;
`else
  assign w_raw = {key_clr_n, key_start_n};
`endif

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_sync1   <= '1;
      r_sync2   <= '1;
      r_db      <= '1;
      r_db_prev <= '1;
      for (int k = 0; k < NK; k++) r_db_cnt[k] <= '0;
    end else begin
      r_sync1   <= w_raw;
      r_sync2   <= r_sync1;
      r_db_prev <= r_db;
      for (int k = 0; k < NK; k++) begin
        if (r_sync2[k] != r_db[k]) begin
          if (r_db_cnt[k] == DB_W'(DB_CYCLES - 1)) begin
            r_db[k]     <= r_sync2[k];
            r_db_cnt[k] <= '0;
          end else begin
            r_db_cnt[k] <= r_db_cnt[k] + DB_W'(1);
          end
        end else begin
          r_db_cnt[k] <= '0;
        end
      end
    end
  end

  // One-cycle pulse in the cycle after a debounced 1->0 edge
  assign w_press = r_db_prev & ~r_db;

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (w_en) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  assign w_en = (r_div_cnt == DIV_W'(DIV - 1));

  // Clear press outranks start; clr stays up through the first en after it is raised
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pause <= 1'b1;
      r_clr   <= 1'b1;
`ifdef STOPWATCH_LAP_EN
      r_lap   <= 1'b0;
`endif
    end else if (w_press[1]) begin
      r_state <= S_IDLE;
      r_pause <= 1'b1;
      r_clr   <= 1'b1;
`ifdef STOPWATCH_LAP_EN
      r_lap   <= 1'b0;
`endif
    end else begin
      if (w_en) r_clr <= 1'b0;
      if (w_press[0]) begin
        case (r_state)
          S_IDLE:   begin r_state <= S_RUN;    r_pause <= 1'b0; end
          S_RUN:    begin r_state <= S_PAUSED; r_pause <= 1'b1; end
          S_PAUSED: begin r_state <= S_RUN;    r_pause <= 1'b0; end
          default:  begin r_state <= S_IDLE;   r_pause <= 1'b1; end
        endcase
`ifdef STOPWATCH_LAP_EN
        r_lap <= 1'b0;
      end else if (w_press[2] && (r_state == S_RUN)) begin
        r_lap <= ~r_lap;
`endif
      end
    end
  end

  assign en    = w_en;
  assign pause = r_pause;
  assign clr   = r_clr;
  assign state = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed and random checks of stopwatch_ctrl against a behavioural model
module tb_stopwatch_ctrl;

  localparam int CLK_HZ    = 1000;
  localparam int TICK_HZ   = 100;
  localparam int DB_CYCLES = 4;
  localparam int DIV       = CLK_HZ / TICK_HZ;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic       key_start_n = 1'b1;
  logic       key_clr_n = 1'b1;
  logic       en;
  logic       pause;
  logic       clr;
  logic [1:0] state;
`ifdef STOPWATCH_LAP_EN
  logic       key_lap_n = 1'b1;
  logic       lap;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Model: raw key history (oldest first), debounced levels, pending falls, cycle count since reset
  logic [2:0] m_hist [$];
  logic [2:0] m_level;
  logic [2:0] m_fall;
  int         m_cyc;
  int         m_state;
  bit         m_clr;
  bit         m_lap;

  stopwatch_ctrl #(
    .CLK_HZ   (CLK_HZ),
    .TICK_HZ  (TICK_HZ),
    .DB_CYCLES(DB_CYCLES)
  ) dut (
    .CLK        (CLK),
    .rst        (rst),
    .key_start_n(key_start_n),
    .key_clr_n  (key_clr_n),
`ifdef STOPWATCH_LAP_EN
    .key_lap_n  (key_lap_n),
    .lap        (lap),
`endif
    .en         (en),
    .pause      (pause),
    .clr        (clr),
    .state      (state)
  );

  always #5 CLK = ~CLK;

  function automatic logic [2:0] raw_keys();
`ifdef STOPWATCH_LAP_EN
    return {key_lap_n, key_clr_n, key_start_n};
`else
    return {1'b1, key_clr_n, key_start_n};
`endif
  endfunction

  task automatic set_key(input int k, input logic v);
    if (k == 0) key_start_n = v;
    else if (k == 1) key_clr_n = v;
`ifdef STOPWATCH_LAP_EN
    else key_lap_n = v;
`endif
  endtask

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    repeat (DB_CYCLES + 2) m_hist.push_back(3'b111);
    m_level = 3'b111;
    m_fall  = 3'b000;
    m_cyc   = 0;
    m_state = 0;
    m_clr   = 1'b1;
    m_lap   = 1'b0;
  endtask

  // A level flips once the last DB_CYCLES synchronised samples (raw delayed two edges) all disagree with it
  task automatic model_edge();
    logic [2:0] press;
    logic [2:0] nlev;
    bit         en_pre;
    bit         all_diff;
    if (rst) begin
      model_reset();
    end else begin
      press  = m_fall;
      en_pre = ((m_cyc % DIV) == DIV - 1);
      if (press[1]) begin
        m_state = 0;
        m_clr   = 1'b1;
        m_lap   = 1'b0;
      end else begin
        if (en_pre) m_clr = 1'b0;
        if (press[0]) begin
          m_state = (m_state == 1) ? 2 : 1;
          m_lap   = 1'b0;
        end else if (press[2] && m_state == 1) begin
          m_lap = !m_lap;
        end
      end
      m_hist.push_back(raw_keys());
      void'(m_hist.pop_front());
      nlev = m_level;
      for (int k = 0; k < 3; k++) begin
        all_diff = 1'b1;
        for (int i = 0; i < DB_CYCLES; i++)
          if (m_hist[i][k] == m_level[k]) all_diff = 1'b0;
        if (all_diff) nlev[k] = ~m_level[k];
      end
      m_fall  = m_level & ~nlev;
      m_level = nlev;
      m_cyc++;
    end
  endtask

  task automatic compare_all();
    check("en", {1'b0, en}, {1'b0, ((m_cyc % DIV) == DIV - 1)});
    check("pause", {1'b0, pause}, {1'b0, (m_state != 1)});
    check("clr", {1'b0, clr}, {1'b0, m_clr});
    check("state", state, 2'(m_state));
`ifdef STOPWATCH_LAP_EN
    check("lap", {1'b0, lap}, {1'b0, m_lap});
`endif
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic press_key(input int k, input int low_n, input int high_n);
    set_key(k, 1'b0);
    repeat (low_n) step();
    set_key(k, 1'b1);
    repeat (high_n) step();
  endtask

  initial begin
    int k_cyc;
    int en_cnt;
    int last_en;
    int hold [3];
    model_reset();

    // Reset held three cycles
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check("rst_en", {1'b0, en}, 2'd0);
    check("rst_pause", {1'b0, pause}, 2'd1);
    check("rst_clr", {1'b0, clr}, 2'd1);
    check("rst_state", state, 2'b00);

    // First en is the 10th cycle after reset; clr drops the cycle after it
    k_cyc = 1;
    while (en !== 1'b1 && k_cyc < 20) begin
      step();
      k_cyc++;
    end
    check("first_en_cycle", 2'(k_cyc), 2'(10));
    check("first_en_cycle_full", {1'b0, (k_cyc == 10)}, 2'd1);
    check("clr_at_first_en", {1'b0, clr}, 2'd1);
    step();
    check("clr_after_first_en", {1'b0, clr}, 2'd0);

    // 100 free-running cycles: ten single-cycle en pulses, 10 apart
    en_cnt  = 0;
    last_en = -1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (en === 1'b1) begin
        if (last_en >= 0) check("en_spacing", {1'b0, (i - last_en == DIV)}, 2'd1);
        en_cnt++;
        last_en = i;
      end
    end
    check("en_count_100", {1'b0, (en_cnt == 10)}, 2'd1);

    // Short glitch is rejected; long press starts the timer
    press_key(0, 3, 12);
    check("glitch_state", state, 2'b00);
    check("glitch_pause", {1'b0, pause}, 2'd1);
    press_key(0, 20, 10);
    check("press_state", state, 2'b01);
    check("press_pause", {1'b0, pause}, 2'd0);

    // Toggle sequence from IDLE
    rst = 1'b1;
    step();
    rst = 1'b0;
    press_key(0, 8, 8);
    check("toggle1_state", state, 2'b01);
    check("toggle1_pause", {1'b0, pause}, 2'd0);
    press_key(0, 8, 8);
    check("toggle2_state", state, 2'b10);
    check("toggle2_pause", {1'b0, pause}, 2'd1);
    press_key(0, 8, 8);
    check("toggle3_state", state, 2'b01);
    check("toggle3_pause", {1'b0, pause}, 2'd0);

    // Clear from RUN; press lands on the 7th edge after the key goes low
    repeat (DIV) step();
    set_key(1, 1'b0);
    repeat (7) step();
    check("clear_state", state, 2'b00);
    check("clear_pause", {1'b0, pause}, 2'd1);
    check("clear_clr", {1'b0, clr}, 2'd1);
    set_key(1, 1'b1);
    k_cyc = 0;
    while (en !== 1'b1 && k_cyc < 2 * DIV) begin
      step();
      k_cyc++;
    end
    check("clear_en_seen", {1'b0, (en === 1'b1)}, 2'd1);
    check("clear_clr_at_en", {1'b0, clr}, 2'd1);
    step();
    check("clear_clr_after_en", {1'b0, clr}, 2'd0);
    repeat (8) step();

    // Start and clear pressed in the same cycle: clear wins
    press_key(0, 8, 8);
    check("simul_pre_state", state, 2'b01);
    key_start_n = 1'b0;
    key_clr_n   = 1'b0;
    repeat (8) step();
    key_start_n = 1'b1;
    key_clr_n   = 1'b1;
    repeat (8) step();
    check("simul_state", state, 2'b00);
    check("simul_clr", {1'b0, (clr === 1'b1 || clr === 1'b0)}, 2'd1);

`ifdef STOPWATCH_LAP_EN
    press_key(0, 8, 8);
    press_key(2, 8, 8);
    check("lap_on", {1'b0, lap}, 2'd1);
    press_key(2, 8, 8);
    check("lap_off", {1'b0, lap}, 2'd0);
    press_key(2, 8, 8);
    check("lap_on2", {1'b0, lap}, 2'd1);
    press_key(0, 8, 8);
    check("lap_pause_state", state, 2'b10);
    check("lap_pause_lap", {1'b0, lap}, 2'd0);
`endif

    // Random key activity with occasional reset
    for (int k = 0; k < 3; k++) hold[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      for (int k = 0; k < 3; k++) begin
        if (hold[k] == 0) begin
          set_key(k, ($urandom_range(0, 2) != 0));
          hold[k] = $urandom_range(1, 10);
        end else begin
          hold[k]--;
        end
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
